// File: rtl/chimera_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chimera_pkg: shared types and default timing for cluster power sequencing  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package chimera_pkg;

  localparam int unsigned ExtClusters              = 5;
  localparam int unsigned c_def_clk_settle_cycles  = 4;
  localparam int unsigned c_def_rst_hold_cycles    = 8;
  localparam int unsigned c_def_iso_timeout_cycles = 256;

  typedef enum logic [2:0] {
    SEQ_IDLE     = 3'd0,
    SEQ_CLK_ON   = 3'd1,
    SEQ_RST_HOLD = 3'd2,
    SEQ_DEISO    = 3'd3,
    SEQ_ISO      = 3'd4,
    SEQ_RST_ON   = 3'd5,
    SEQ_CLK_OFF  = 3'd6
  } cluster_seq_state_e;

  // Terminal count for a state lasting 'cycles' cycles; zero still means one cycle.
  function automatic int unsigned cyc_last(input int unsigned cycles);
    return (cycles == 0) ? 0 : cycles - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb_tree.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arb_tree: round-robin selector, search starts after the last grant      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_arb_tree #(
  parameter int unsigned NumIn    = 2,
  parameter int unsigned IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumIn-1:0]    req_i,
  input  logic                gnt_i,
  output logic                req_o,
  output logic [IdxWidth-1:0] idx_o
);

  localparam logic [IdxWidth-1:0] c_last_idx = IdxWidth'(NumIn - 1);

  logic [IdxWidth-1:0] r_ptr;
  logic [IdxWidth-1:0] w_idx;
  logic                w_found;
  int                  w_j;

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_j     = 0;
    for (int k = 0; k < int'(NumIn); k++) begin
      w_j = (int'(r_ptr) + k) % int'(NumIn);
      if (!w_found && req_i[IdxWidth'(w_j)]) begin
        w_found = 1'b1;
        w_idx   = IdxWidth'(w_j);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (w_found && gnt_i) begin
      r_ptr <= (w_idx == c_last_idx) ? '0 : w_idx + 1'b1;
    end
  end

  assign req_o = w_found;
  assign idx_o = w_idx;

endmodule
`default_nettype wire

// File: rtl/chimera_cluster_pwr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chimera_cluster_pwr_seq: one-at-a-time clock/reset/isolation sequencer     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module chimera_cluster_pwr_seq
  import chimera_pkg::*;
#(
  parameter int unsigned NumClusters      = ExtClusters,
  parameter int unsigned ClkSettleCycles  = c_def_clk_settle_cycles,
  parameter int unsigned RstHoldCycles    = c_def_rst_hold_cycles,
  parameter int unsigned IsoTimeoutCycles = c_def_iso_timeout_cycles
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumClusters-1:0] cluster_en_i,
  input  logic [NumClusters-1:0] cluster_isolated_i,
  output logic [NumClusters-1:0] cluster_clk_en_o,
  output logic [NumClusters-1:0] cluster_rst_no,
  output logic [NumClusters-1:0] cluster_isolate_o,
  output logic [NumClusters-1:0] cluster_ready_o,
  output logic [NumClusters-1:0] err_o,
  output logic                   busy_o
);

  localparam int unsigned c_idx_w   = (NumClusters > 1) ? $clog2(NumClusters) : 1;
  localparam int unsigned c_max_a   = (ClkSettleCycles > RstHoldCycles) ? ClkSettleCycles : RstHoldCycles;
  localparam int unsigned c_max_cyc = (c_max_a > IsoTimeoutCycles) ? c_max_a : IsoTimeoutCycles;
  localparam int unsigned c_cnt_w   = (c_max_cyc > 0) ? $clog2(c_max_cyc + 1) : 1;

  localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(cyc_last(ClkSettleCycles));
  localparam logic [c_cnt_w-1:0] c_hold_last   = c_cnt_w'(cyc_last(RstHoldCycles));
  localparam logic [c_cnt_w-1:0] c_iso_last    = c_cnt_w'(cyc_last(IsoTimeoutCycles));

  cluster_seq_state_e r_state, w_state_d;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_d;
  logic [c_idx_w-1:0] r_idx, w_idx_d;

  logic [NumClusters-1:0] r_clk_en, w_clk_en_d;
  logic [NumClusters-1:0] r_rst_n,  w_rst_n_d;
  logic [NumClusters-1:0] r_iso,    w_iso_d;
  logic [NumClusters-1:0] r_ready,  w_ready_d;
  logic [NumClusters-1:0] r_err,    w_err_d;

  logic [NumClusters-1:0] w_pending;
  logic                   w_arb_valid;
  logic [c_idx_w-1:0]     w_arb_idx;
  logic                   w_arb_gnt;
  logic                   w_ack_lo;
  logic                   w_ack_hi;

  assign w_pending = cluster_en_i ^ r_ready;
  assign w_arb_gnt = (r_state == SEQ_IDLE);
  assign w_ack_lo  = ~cluster_isolated_i[r_idx];
  assign w_ack_hi  = cluster_isolated_i[r_idx];

  rr_arb_tree #(
    .NumIn    (NumClusters),
    .IdxWidth (c_idx_w)
  ) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (w_pending),
    .gnt_i  (w_arb_gnt),
    .req_o  (w_arb_valid),
    .idx_o  (w_arb_idx)
  );

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_idx_d    = r_idx;
    w_clk_en_d = r_clk_en;
    w_rst_n_d  = r_rst_n;
    w_iso_d    = r_iso;
    w_ready_d  = r_ready;
    w_err_d    = r_err;
    case (r_state)
      SEQ_IDLE: begin
        if (w_arb_valid) begin
          w_idx_d            = w_arb_idx;
          w_cnt_d            = '0;
          w_err_d[w_arb_idx] = 1'b0;
          // A cluster that is not ready is being powered up, otherwise down.
          if (!r_ready[w_arb_idx]) begin
            w_state_d             = SEQ_CLK_ON;
            w_clk_en_d[w_arb_idx] = 1'b1;
          end else begin
            w_state_d          = SEQ_ISO;
            w_iso_d[w_arb_idx] = 1'b1;
          end
        end
      end
      SEQ_CLK_ON: begin
        if (r_cnt >= c_settle_last) begin
          w_state_d        = SEQ_RST_HOLD;
          w_cnt_d          = '0;
          w_rst_n_d[r_idx] = 1'b0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      SEQ_RST_HOLD: begin
        if (r_cnt >= c_hold_last) begin
          w_state_d        = SEQ_DEISO;
          w_cnt_d          = '0;
          w_rst_n_d[r_idx] = 1'b1;
          w_iso_d[r_idx]   = 1'b0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      SEQ_DEISO: begin
        if (w_ack_lo || (r_cnt >= c_iso_last)) begin
          w_state_d        = SEQ_IDLE;
          w_ready_d[r_idx] = 1'b1;
          w_err_d[r_idx]   = ~w_ack_lo;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      SEQ_ISO: begin
        if (w_ack_hi || (r_cnt >= c_iso_last)) begin
          w_state_d        = SEQ_RST_ON;
          w_cnt_d          = '0;
          w_rst_n_d[r_idx] = 1'b0;
          w_err_d[r_idx]   = ~w_ack_hi;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      SEQ_RST_ON: begin
        if (r_cnt >= c_settle_last) begin
          w_state_d         = SEQ_CLK_OFF;
          w_cnt_d           = '0;
          w_clk_en_d[r_idx] = 1'b0;
          w_ready_d[r_idx]  = 1'b0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      SEQ_CLK_OFF: w_state_d = SEQ_IDLE;
      default:     w_state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= SEQ_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_clk_en <= '0;
      r_rst_n  <= '0;
      r_iso    <= '1;
      r_ready  <= '0;
      r_err    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_idx    <= w_idx_d;
      r_clk_en <= w_clk_en_d;
      r_rst_n  <= w_rst_n_d;
      r_iso    <= w_iso_d;
      r_ready  <= w_ready_d;
      r_err    <= w_err_d;
    end
  end

  assign cluster_clk_en_o  = r_clk_en;
  assign cluster_rst_no    = r_rst_n;
  assign cluster_isolate_o = r_iso;
  assign cluster_ready_o   = r_ready;
  assign err_o             = r_err;
  assign busy_o            = (r_state != SEQ_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_chimera_cluster_pwr_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_chimera_cluster_pwr_seq: randomized bench with elapsed-time reference   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_chimera_cluster_pwr_seq;

  localparam int N   = 5;
  localparam int S_P = 4;    // clock settle cycles
  localparam int H_P = 8;    // reset hold cycles
  localparam int T_P = 256;  // isolation timeout cycles

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] en = '0;
  logic [N-1:0] isolated = '1;
  logic [N-1:0] clk_en_o, crst_n_o, iso_o, ready_o, err_o;
  logic         busy_o;

  chimera_cluster_pwr_seq dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .cluster_en_i       (en),
    .cluster_isolated_i (isolated),
    .cluster_clk_en_o   (clk_en_o),
    .cluster_rst_no     (crst_n_o),
    .cluster_isolate_o  (iso_o),
    .cluster_ready_o    (ready_o),
    .err_o              (err_o),
    .busy_o             (busy_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: timing expressed as cycles elapsed since the grant.
  int           m_ptr, m_act, m_t, m_mark;
  bit           m_busy, m_up;
  bit [N-1:0]   m_clk, m_rst, m_iso, m_rdy, m_err;
  int           lag [N];
  int           dly [N];
  bit [N-1:0]   stuck = '0;

  task automatic model_reset();
    m_ptr = 0; m_busy = 0; m_act = 0; m_t = 0; m_mark = -1; m_up = 0;
    m_clk = '0; m_rst = '0; m_iso = '1; m_rdy = '0; m_err = '0;
  endtask

  task automatic model_step();
    bit [N-1:0] pend;
    int a, c;
    if (!m_busy) begin
      pend = en ^ m_rdy;
      if (pend != '0) begin
        a = -1;
        for (int k = 0; k < N; k++)
          if (a < 0 && pend[(m_ptr + k) % N]) a = (m_ptr + k) % N;
        m_act = a; m_ptr = (a + 1) % N; m_up = !m_rdy[a];
        m_t = 1; m_mark = -1; m_busy = 1; m_err[a] = 0;
        if (m_up) m_clk[a] = 1; else m_iso[a] = 1;
      end
    end else begin
      a = m_act;
      c = m_t;
      if (m_up) begin
        if (c == S_P + H_P) begin
          m_rst[a] = 1; m_iso[a] = 0;
        end else if (c > S_P + H_P) begin
          if (!isolated[a] || (c - (S_P + H_P)) >= T_P) begin
            m_rdy[a] = 1; m_err[a] = isolated[a]; m_busy = 0;
          end
        end
      end else begin
        if (m_mark < 0) begin
          if (isolated[a] || c >= T_P) begin
            m_rst[a] = 0; m_err[a] = !isolated[a]; m_mark = c + 1;
          end
        end else if (c == m_mark + S_P - 1) begin
          m_clk[a] = 0; m_rdy[a] = 0;
        end else if (c == m_mark + S_P) begin
          m_busy = 0;
        end
      end
      m_t = c + 1;
    end
  endtask

  // Cluster side: isolation ack follows the requested isolate after dly[i] cycles.
  task automatic respond();
    for (int i = 0; i < N; i++) begin
      if (stuck[i]) continue;
      if (isolated[i] != m_iso[i]) begin
        lag[i]++;
        if (lag[i] > dly[i]) begin
          isolated[i] = m_iso[i];
          lag[i] = 0;
        end
      end else begin
        lag[i] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    @(negedge clk);
    chk("clk_en", clk_en_o, m_clk);
    chk("rst_n",  crst_n_o, m_rst);
    chk("iso",    iso_o,    m_iso);
    chk("ready",  ready_o,  m_rdy);
    chk("err",    err_o,    m_err);
    chk("busy",   busy_o,   m_busy);
    respond();
  endtask

  task automatic run_until_quiet(input int limit);
    bit quiet;
    quiet = 0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (!m_busy && ((en ^ m_rdy) == '0)) begin
        quiet = 1;
        break;
      end
    end
    chk("quiet", quiet, 1);
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_clk_en"}, clk_en_o, 0);
    chk({tag, "_rst_n"},  crst_n_o, 0);
    chk({tag, "_iso"},    iso_o,    5'h1f);
    chk({tag, "_ready"},  ready_o,  0);
    chk({tag, "_err"},    err_o,    0);
    chk({tag, "_busy"},   busy_o,   0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_clk, t_rst, t_rdy, t_rlo, t_off;
    int q_order[$];
    int max_ovl;
    bit seen;
    logic [N-1:0] prev;

    for (int i = 0; i < N; i++) begin lag[i] = 0; dly[i] = 1; end
    model_reset();

    // Reset state
    tick(); tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // Single power-up of cluster 0 with a 2-cycle isolation release
    dly[0] = 2;
    en[0] = 1'b1;
    t_clk = -1; t_rst = -1; t_rdy = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (t_clk < 0 && clk_en_o[0]) t_clk = k;
      if (t_rst < 0 && crst_n_o[0]) t_rst = k;
      if (t_rdy < 0 && ready_o[0])  t_rdy = k;
    end
    chk("up_clk_cycle", t_clk, 1);
    chk("up_rst_cycle", t_rst, 13);
    chk("up_rdy_cycle", t_rdy, 16);

    // Power-down of cluster 0 with a 3-cycle isolation ack
    dly[0] = 3;
    en[0] = 1'b0;
    t_rlo = -1; t_off = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (t_rlo < 0 && !crst_n_o[0]) t_rlo = k;
      if (t_off < 0 && !clk_en_o[0]) t_off = k;
    end
    chk("dn_rst_low_cycle", t_rlo, 5);
    chk("dn_rst_low_len", t_off - t_rlo, 4);
    chk("dn_iso_kept", iso_o[0], 1);
    chk("dn_ready_off", ready_o[0], 0);

    // Reset asserted mid-CLK_ON takes effect without a clock edge
    en[2] = 1'b1;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    model_reset();
    en = '0;
    tick(); tick();
    rst_n = 1'b1;
    run_until_quiet(50);

    // Contention: 0, 2 and 4 requested together, served one at a time
    for (int i = 0; i < N; i++) dly[i] = $urandom_range(0, 4);
    prev = clk_en_o;
    max_ovl = 0;
    en = 5'b10101;
    for (int k = 0; k < 200; k++) begin
      tick();
      for (int i = 0; i < N; i++)
        if (clk_en_o[i] && !prev[i]) q_order.push_back(i);
      if ($countones(clk_en_o ^ ready_o) > max_ovl) max_ovl = $countones(clk_en_o ^ ready_o);
      prev = clk_en_o;
      if (!m_busy && ((en ^ m_rdy) == '0)) break;
    end
    chk("cont_count", q_order.size(), 3);
    if (q_order.size() == 3) begin
      chk("cont_first",  q_order[0], 0);
      chk("cont_second", q_order[1], 2);
      chk("cont_third",  q_order[2], 4);
    end
    chk("cont_overlap", max_ovl, 1);
    en = '0;
    run_until_quiet(300);

    // Isolation ack stuck high on power-up of cluster 1
    stuck[1] = 1'b1;
    isolated[1] = 1'b1;
    en[1] = 1'b1;
    run_until_quiet(400);
    chk("to_err", err_o[1], 1);
    chk("to_ready", ready_o[1], 1);
    en[1] = 1'b0;
    tick();
    chk("to_err_clear", err_o[1], 0);
    run_until_quiet(100);
    stuck[1] = 1'b0;

    // Request withdrawn during RST_HOLD: power-up finishes, then power-down
    en[3] = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    en[3] = 1'b0;
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (ready_o[3]) seen = 1;
      if (!m_busy && ((en ^ m_rdy) == '0)) break;
    end
    chk("toggle_up_seen", seen, 1);
    chk("toggle_final", ready_o[3], 0);
    run_until_quiet(50);

    // Random requests and acknowledge latencies
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        int b;
        b = $urandom_range(0, N - 1);
        en[b] = ~en[b];
        dly[b] = $urandom_range(0, 4);
      end
      tick();
    end
    run_until_quiet(2000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
